// File: rtl/rect_fill_engine_if.sv
// SRAM arbiter port of the rectangle fill engine.
// One read or write request per cycle, stalled by mem_ready.
interface rect_fill_engine_if #(
    parameter int ADDR_W  = 16,
    parameter int PIX_W   = 24,
    parameter int LAYER_W = 2
);
    logic                     read_enable;
    logic                     write_enable;
    logic [ADDR_W-1:0]        address;
    logic [PIX_W+LAYER_W-1:0] write_data;
    logic                     mem_ready;
    logic [PIX_W+LAYER_W-1:0] read_data;

    modport master (
        output read_enable, write_enable, address, write_data,
        input  mem_ready, read_data
    );

    modport slave (
        input  read_enable, write_enable, address, write_data,
        output mem_ready, read_data
    );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle fill into the frame-buffer SRAM, one pixel per transaction.
// Modes: solid, checker texture, layer-gated read-compare-write.
module rect_fill_engine #(
    parameter int COORD_W   = 8,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int PIX_W     = 24,
    parameter int LAYER_W   = 2,
    parameter int ADDR_W    = 16,
    parameter int TEX_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 fill_start,
    input  logic [4*COORD_W-1:0] coordinates,
    input  logic [1:0]           fill_mode,
    input  logic [PIX_W-1:0]     color_code,
    input  logic [PIX_W-1:0]     texture_code,
    input  logic [LAYER_W-1:0]   layer_num,
    rect_fill_engine_if.master   sram,
    output logic [COORD_W-1:0]   xmin,
    output logic [COORD_W-1:0]   ymin,
    output logic [COORD_W-1:0]   xmax,
    output logic [COORD_W-1:0]   ymax,
    output logic                 busy,
    output logic                 fill_done
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] WR    = 3'd2;
    localparam logic [2:0] RD    = 3'd3;
    localparam logic [2:0] CMP   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(FB_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(FB_HEIGHT - 1);
    localparam logic [ADDR_W-1:0]  FBW   = ADDR_W'(FB_WIDTH);

    logic [2:0]           state;
    logic [4*COORD_W-1:0] cmd_coord;
    logic [1:0]           cmd_mode;
    logic [PIX_W-1:0]     cmd_color;
    logic [PIX_W-1:0]     cmd_tex;
    logic [LAYER_W-1:0]   cmd_layer;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;

    logic [COORD_W-1:0] x1, y1, x2, y2;
    logic [COORD_W-1:0] lo_x, hi_x, lo_y, hi_y;
    logic [COORD_W-1:0] cx_lo, cx_hi, cy_lo, cy_hi;
    logic [COORD_W-1:0] step_x, step_y;
    logic [2:0]         step_state;
    logic [COORD_W-1:0] tx;
    logic               layered;
    logic               tex_sel;
    logic [ADDR_W-1:0]  pix_addr;
    logic [PIX_W-1:0]   pix_color;
    logic [LAYER_W-1:0] rd_tag;
    logic               unused_bits;

    assign x1 = cmd_coord[4*COORD_W-1 -: COORD_W];
    assign y1 = cmd_coord[3*COORD_W-1 -: COORD_W];
    assign x2 = cmd_coord[2*COORD_W-1 -: COORD_W];
    assign y2 = cmd_coord[COORD_W-1:0];

    // Sort each axis, then pull anything past the edge back onto it.
    assign lo_x  = (x1 < x2) ? x1 : x2;
    assign hi_x  = (x1 < x2) ? x2 : x1;
    assign lo_y  = (y1 < y2) ? y1 : y2;
    assign hi_y  = (y1 < y2) ? y2 : y1;
    assign cx_lo = (lo_x > X_LIM) ? X_LIM : lo_x;
    assign cx_hi = (hi_x > X_LIM) ? X_LIM : hi_x;
    assign cy_lo = (lo_y > Y_LIM) ? Y_LIM : lo_y;
    assign cy_hi = (hi_y > Y_LIM) ? Y_LIM : hi_y;

    assign layered   = (cmd_mode == 2'b10);
    assign tx        = (x >> TEX_SHIFT) ^ (y >> TEX_SHIFT);
    assign tex_sel   = tx[0] & (cmd_mode == 2'b01);
    assign pix_color = tex_sel ? cmd_tex : cmd_color;
    assign pix_addr  = ADDR_W'(y) * FBW + ADDR_W'(x);
    assign rd_tag    = sram.read_data[PIX_W +: LAYER_W];

    assign unused_bits = ^{tx[COORD_W-1:1], sram.read_data[PIX_W-1:0]};

    always_comb begin
        step_x     = x;
        step_y     = y;
        step_state = layered ? RD : WR;
        if (x < xmax) begin
            step_x = x + 1'b1;
        end else if (y < ymax) begin
            step_x = xmin;
            step_y = y + 1'b1;
        end else begin
            step_state = DONE;
        end
    end

    assign sram.write_enable = (state == WR);
    assign sram.read_enable  = (state == RD);
    assign sram.address      = (state == WR || state == RD) ? pix_addr : '0;
    assign sram.write_data   = (state == WR) ? {cmd_layer, pix_color} : '0;
    assign fill_done         = (state == DONE);
    assign busy = (state == SETUP) || (state == WR) ||
                  (state == RD) || (state == CMP);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cmd_coord <= '0;
            cmd_mode  <= '0;
            cmd_color <= '0;
            cmd_tex   <= '0;
            cmd_layer <= '0;
            x         <= '0;
            y         <= '0;
            xmin      <= '0;
            ymin      <= '0;
            xmax      <= '0;
            ymax      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fill_start) begin
                        cmd_coord <= coordinates;
                        cmd_mode  <= fill_mode;
                        cmd_color <= color_code;
                        cmd_tex   <= texture_code;
                        cmd_layer <= layer_num;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    xmin  <= cx_lo;
                    xmax  <= cx_hi;
                    ymin  <= cy_lo;
                    ymax  <= cy_hi;
                    x     <= cx_lo;
                    y     <= cy_lo;
                    state <= layered ? RD : WR;
                end
                WR: begin
                    if (sram.mem_ready) begin
                        x     <= step_x;
                        y     <= step_y;
                        state <= step_state;
                    end
                end
                RD: begin
                    if (sram.mem_ready) state <= CMP;
                end
                CMP: begin
                    if (cmd_layer >= rd_tag) begin
                        state <= WR;
                    end else begin
                        x     <= step_x;
                        y     <= step_y;
                        state <= step_state;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: expected writes are queued by the
// stimulus and popped by a monitor on every accepted write.
module tb_rect_fill_engine;
    typedef struct packed {
        logic [15:0] a;
        logic [25:0] d;
    } txn_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        fill_start = 1'b0;
    logic [31:0] coordinates = '0;
    logic [1:0]  fill_mode = '0;
    logic [23:0] color_code = '0;
    logic [23:0] texture_code = '0;
    logic [1:0]  layer_num = '0;
    logic [7:0]  xmin, ymin, xmax, ymax;
    logic        busy, fill_done;

    logic [1:0]  lay [0:255];
    txn_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          sb_on = 1'b1;

    rect_fill_engine_if #(.ADDR_W(16), .PIX_W(24), .LAYER_W(2)) sram_bus();

    rect_fill_engine dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .fill_start   (fill_start),
        .coordinates  (coordinates),
        .fill_mode    (fill_mode),
        .color_code   (color_code),
        .texture_code (texture_code),
        .layer_num    (layer_num),
        .sram         (sram_bus),
        .xmin         (xmin),
        .ymin         (ymin),
        .xmax         (xmax),
        .ymax         (ymax),
        .busy         (busy),
        .fill_done    (fill_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_bus.read_enable && sram_bus.mem_ready)
            sram_bus.read_data <= {lay[sram_bus.address[7:0]], 24'h0};
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [25:0] d);
        txn_t t;
        t.a = a;
        t.d = d;
        q.push_back(t);
    endtask

    always @(negedge clk) begin
        txn_t t;
        if (sb_on && n_rst) begin
            if (sram_bus.read_enable && sram_bus.write_enable)
                check("rd_wr_exclusive", 32'd1, 32'd0);
            if (sram_bus.write_enable && sram_bus.mem_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_write", {16'h0, sram_bus.address},
                          32'hFFFF_FFFF);
                end else begin
                    t = q.pop_front();
                    check("wr_addr", {16'h0, sram_bus.address}, {16'h0, t.a});
                    check("wr_data", {6'h0, sram_bus.write_data}, {6'h0, t.d});
                end
            end
        end
    end

    task automatic start(input logic [7:0] x1, input logic [7:0] y1,
                         input logic [7:0] x2, input logic [7:0] y2,
                         input logic [1:0] m, input logic [1:0] l);
        coordinates = {x1, y1, x2, y2};
        fill_mode   = m;
        layer_num   = l;
        fill_start  = 1'b1;
        @(posedge clk); #1;
        fill_start  = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_cyc, input int c0);
        int c = c0;
        while (!fill_done && c < 300) begin
            @(posedge clk); #1;
            c++;
        end
        check({nm, "_done_cycle"}, c, exp_cyc);
        check({nm, "_busy_at_done"}, {31'h0, busy}, 32'd0);
        check({nm, "_queue_empty"}, q.size(), 0);
        @(posedge clk); #1;
        check({nm, "_done_pulse"}, {31'h0, fill_done}, 32'd0);
    endtask

    task automatic check_bounds(input string nm, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] c,
                                input logic [7:0] d);
        check(nm, {xmin, ymin, xmax, ymax}, {a, b, c, d});
    endtask

    initial begin
        int c;
        int bad;
        for (int i = 0; i < 256; i++) lay[i] = 2'd0;
        lay[1] = 2'd2;
        lay[2] = 2'd1;
        sram_bus.mem_ready = 1'b1;
        sram_bus.read_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_we", {31'h0, sram_bus.write_enable}, 32'd0);
        check("rst_re", {31'h0, sram_bus.read_enable}, 32'd0);
        check("rst_addr", {16'h0, sram_bus.address}, 32'd0);
        check("rst_wdata", {6'h0, sram_bus.write_data}, 32'd0);
        check("rst_busy_done", {30'h0, busy, fill_done}, 32'd0);
        check_bounds("rst_bounds", 8'd0, 8'd0, 8'd0, 8'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Solid fill, with a stray start and new coords while busy.
        color_code = 24'hC0FFEE;
        foreach (q[i]) q.delete(i);
        push(16'd162, {2'd2, 24'hC0FFEE});
        push(16'd163, {2'd2, 24'hC0FFEE});
        push(16'd164, {2'd2, 24'hC0FFEE});
        push(16'd322, {2'd2, 24'hC0FFEE});
        push(16'd323, {2'd2, 24'hC0FFEE});
        push(16'd324, {2'd2, 24'hC0FFEE});
        start(8'd2, 8'd1, 8'd4, 8'd2, 2'b00, 2'd2);
        check("t1_busy", {31'h0, busy}, 32'd1);
        @(posedge clk); #1;
        coordinates = {8'd9, 8'd9, 8'd9, 8'd9};
        color_code  = 24'h0;
        fill_start  = 1'b1;
        @(posedge clk); #1;
        fill_start  = 1'b0;
        wait_done("t1", 8, 3);
        check_bounds("t1_bounds", 8'd2, 8'd1, 8'd4, 8'd2);

        // Swapped corners, mode 11 behaves as solid.
        color_code = 24'h123456;
        push(16'd162, {2'd0, 24'h123456});
        push(16'd163, {2'd0, 24'h123456});
        push(16'd164, {2'd0, 24'h123456});
        push(16'd322, {2'd0, 24'h123456});
        push(16'd323, {2'd0, 24'h123456});
        push(16'd324, {2'd0, 24'h123456});
        start(8'd4, 8'd2, 8'd2, 8'd1, 2'b11, 2'd0);
        wait_done("t2", 8, 1);
        check_bounds("t2_bounds", 8'd2, 8'd1, 8'd4, 8'd2);

        // Checker row y=0, x=0..7.
        color_code   = 24'h112233;
        texture_code = 24'hAABBCC;
        for (int i = 0; i < 4; i++) push(16'(i), {2'd3, 24'h112233});
        for (int i = 4; i < 8; i++) push(16'(i), {2'd3, 24'hAABBCC});
        start(8'd0, 8'd0, 8'd7, 8'd0, 2'b01, 2'd3);
        wait_done("t3", 10, 1);

        // Layered: stored tags 0,2,1 -> pixels 0 and 2 written.
        color_code = 24'h00FF00;
        push(16'd0, {2'd1, 24'h00FF00});
        push(16'd2, {2'd1, 24'h00FF00});
        start(8'd0, 8'd0, 8'd2, 8'd0, 2'b10, 2'd1);
        wait_done("t4", 10, 1);

        // Clip to the bottom-right corner: x 150..159, y 118..119.
        color_code = 24'h0000AA;
        for (int yy = 118; yy < 120; yy++)
            for (int xx = 150; xx < 160; xx++)
                push(16'(yy * 160 + xx), {2'd0, 24'h0000AA});
        start(8'd150, 8'd118, 8'd255, 8'd200, 2'b00, 2'd0);
        wait_done("t5", 22, 1);
        check_bounds("t5_bounds", 8'd150, 8'd118, 8'd159, 8'd119);

        // Three-cycle stall on pixel 802 of row y=5.
        color_code = 24'h555555;
        for (int i = 0; i < 6; i++) push(16'(800 + i), {2'd1, 24'h555555});
        start(8'd0, 8'd5, 8'd5, 8'd5, 2'b00, 2'd1);
        c = 1;
        for (int i = 0; i < 20; i++) begin
            if (sram_bus.write_enable && sram_bus.address == 16'd802) break;
            @(posedge clk); #1;
            c++;
        end
        check("t6_reach_802", {16'h0, sram_bus.address}, 32'd802);
        sram_bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            c++;
            check("t6_stall_addr", {16'h0, sram_bus.address}, 32'd802);
            check("t6_stall_ctl",
                  {30'h0, sram_bus.write_enable, sram_bus.read_enable}, 32'd2);
            check("t6_stall_data", {6'h0, sram_bus.write_data},
                  {6'h0, 2'd1, 24'h555555});
        end
        sram_bus.mem_ready = 1'b1;
        wait_done("t6", 11, c);

        // Reset in the middle of a large fill.
        sb_on = 1'b0;
        start(8'd0, 8'd0, 8'd9, 8'd9, 2'b00, 2'd0);
        repeat (5) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #2;
        check("t7_rst_ctl", {28'h0, sram_bus.write_enable,
              sram_bus.read_enable, busy, fill_done}, 32'd0);
        check("t7_rst_addr", {16'h0, sram_bus.address}, 32'd0);
        check("t7_rst_wdata", {6'h0, sram_bus.write_data}, 32'd0);
        check_bounds("t7_rst_bounds", 8'd0, 8'd0, 8'd0, 8'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (fill_done || busy || sram_bus.write_enable ||
                sram_bus.read_enable) bad++;
        end
        check("t7_quiet_after_rst", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
